// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Desc     : Shared constants for the MNIST layer sequencer: layer indices,
//            layer count, default per-layer timeout and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int NUM_LAYERS             = 5;
    localparam int TIMEOUT_CYCLES_DEFAULT = 65535;

    // Layer indices in issue order
    localparam logic [2:0] L_CONV1 = 3'd0;
    localparam logic [2:0] L_POOL1 = 3'd1;
    localparam logic [2:0] L_CONV2 = 3'd2;
    localparam logic [2:0] L_POOL2 = 3'd3;
    localparam logic [2:0] L_FC    = 3'd4;

    // Sequencer state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] c_ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] c_ST_START = 3'd1;
    localparam logic [STATE_W-1:0] c_ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] c_ST_NEXT  = 3'd3;
    localparam logic [STATE_W-1:0] c_ST_DONE  = 3'd4;
    localparam logic [STATE_W-1:0] c_ST_ERROR = 3'd5;

endpackage
`default_nettype wire

// File: rtl/seq_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : seq_timeout_counter
// Desc     : Clearable up-counter with a terminal-count flag. Optionally
//            saturates at the terminal value instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module seq_timeout_counter #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TERMINAL = '1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == TERMINAL);

    // Count register: clear wins over increment; saturating mode parks at TERMINAL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(SATURATE && tc)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_sequencer
// Desc     : Run-level controller for the inference pipeline. Starts each
//            layer in order, waits for its finish pulse with a timeout guard,
//            and reports completion, sticky timeout error and run latency.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS     = cnn_pkg::NUM_LAYERS,
    parameter int TIMEOUT_CYCLES = cnn_pkg::TIMEOUT_CYCLES_DEFAULT,
    parameter int CNT_WIDTH      = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run_start,
    input  logic                  abort,
    input  logic                  err_clear,
    input  logic [NUM_LAYERS-1:0] layer_finish,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [2:0]            active_layer,
    output logic                  busy,
    output logic                  run_done,
    output logic                  run_error,
    output logic [2:0]            err_layer,
    output logic [CNT_WIDTH-1:0]  run_cycles
);

    import cnn_pkg::*;

    localparam int                  TO_WIDTH      = $clog2(TIMEOUT_CYCLES);
    localparam logic [2:0]          c_LAST        = 3'(NUM_LAYERS - 1);
    // The counter lands on TIMEOUT_CYCLES-1 on the same edge that enters ERROR
    localparam logic [TO_WIDTH-1:0] c_TO_TERMINAL = TO_WIDTH'(TIMEOUT_CYCLES - 2);

    logic [STATE_W-1:0]  r_state;
    logic [2:0]          r_cur;
    logic [2:0]          w_cur_inc;
    logic                w_finish;
    logic                w_timeout;
    logic                w_to_clr;
    logic                w_to_inc;
    logic                w_run_clr;
    logic                w_run_inc;
    logic [TO_WIDTH-1:0] w_to_count;
    logic                w_run_tc;
    logic                w_unused;

    assign w_cur_inc = r_cur + 3'd1;
    // Only the awaited layer's finish matters; all other bits are ignored
    assign w_finish  = layer_finish[r_cur];

    assign w_to_clr  = (r_state == c_ST_START);
    assign w_to_inc  = (r_state == c_ST_WAIT);
    assign w_run_clr = (r_state == c_ST_IDLE) && run_start && !abort;
    assign w_run_inc = (r_state == c_ST_START) || (r_state == c_ST_WAIT) ||
                       (r_state == c_ST_NEXT);

    seq_timeout_counter #(
        .WIDTH    (TO_WIDTH),
        .TERMINAL (c_TO_TERMINAL),
        .SATURATE (1'b0)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_to_clr),
        .inc     (w_to_inc),
        .count   (w_to_count),
        .tc      (w_timeout)
    );

    seq_timeout_counter #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL ({CNT_WIDTH{1'b1}}),
        .SATURATE (1'b1)
    ) u_run_cycles (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_run_clr),
        .inc     (w_run_inc),
        .count   (run_cycles),
        .tc      (w_run_tc)
    );

    // Timeout count value and run-counter saturation flag are not needed here
    assign w_unused = ^{w_to_count, w_run_tc};

    // Sequencing FSM; every host- and layer-facing output is registered here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_IDLE;
            r_cur        <= L_CONV1;
            layer_start  <= '0;
            active_layer <= '0;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            run_error    <= 1'b0;
            err_layer    <= '0;
        end else begin
            layer_start <= '0;
            run_done    <= 1'b0;
            if (abort) begin
                r_state      <= c_ST_IDLE;
                r_cur        <= L_CONV1;
                active_layer <= '0;
                busy         <= 1'b0;
                run_error    <= 1'b0;
                err_layer    <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (run_start) begin
                            r_state              <= c_ST_START;
                            r_cur                <= L_CONV1;
                            layer_start[L_CONV1] <= 1'b1;
                            active_layer         <= L_CONV1;
                            busy                 <= 1'b1;
                        end
                    end
                    c_ST_START: begin
                        r_state <= c_ST_WAIT;
                    end
                    c_ST_WAIT: begin
                        if (w_finish) begin
                            if (r_cur == c_LAST) begin
                                r_state      <= c_ST_DONE;
                                run_done     <= 1'b1;
                                busy         <= 1'b0;
                                active_layer <= '0;
                            end else begin
                                r_state <= c_ST_NEXT;
                            end
                        end else if (w_timeout) begin
                            r_state      <= c_ST_ERROR;
                            run_error    <= 1'b1;
                            err_layer    <= r_cur;
                            busy         <= 1'b0;
                            active_layer <= '0;
                        end
                    end
                    c_ST_NEXT: begin
                        r_state                <= c_ST_START;
                        r_cur                  <= w_cur_inc;
                        layer_start[w_cur_inc] <= 1'b1;
                        active_layer           <= w_cur_inc;
                    end
                    c_ST_DONE: begin
                        r_state <= c_ST_IDLE;
                    end
                    c_ST_ERROR: begin
                        if (err_clear) begin
                            r_state   <= c_ST_IDLE;
                            run_error <= 1'b0;
                            err_layer <= '0;
                        end
                    end
                    default: begin
                        r_state      <= c_ST_IDLE;
                        busy         <= 1'b0;
                        active_layer <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnn_layer_sequencer
// Desc     : Self-checking bench for cnn_layer_sequencer: table of runs with
//            per-layer finish delays, event scoreboard, and hand sequences
//            for abort, error handling and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_sequencer;

    localparam int NL = 5;
    localparam int TO = 50;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          run_start;
    logic          abort;
    logic          err_clear;
    logic [NL-1:0] layer_finish;
    logic [NL-1:0] layer_start;
    logic [2:0]    active_layer;
    logic          busy;
    logic          run_done;
    logic          run_error;
    logic [2:0]    err_layer;
    logic [CW-1:0] run_cycles;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(
        .NUM_LAYERS     (NL),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .run_start    (run_start),
        .abort        (abort),
        .err_clear    (err_clear),
        .layer_finish (layer_finish),
        .layer_start  (layer_start),
        .active_layer (active_layer),
        .busy         (busy),
        .run_done     (run_done),
        .run_error    (run_error),
        .err_layer    (err_layer),
        .run_cycles   (run_cycles)
    );

    typedef enum int {EV_START, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       idx;
        int       cycles;
    } ev_t;

    typedef struct {
        int d[NL];      // finish delay per layer, 0 = never finishes
        bit spur;       // inject spurious finishes / run_start during layer 1
        bit exp_err;
        int exp_layer;
        int exp_cycles;
    } vec_t;

    ev_t  sb[$];
    vec_t tbl[6];

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int n_done = 0;
    int first_start = 0;
    int delay[NL];
    int due[NL];
    bit spur_en = 1'b0;
    int rs_spur = -1, sp3 = -1, sp0a = -1, sp0b = -1;
    bit prev_err = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < NL; k++) due[k] = -1;
        sb.delete();
        spur_en = 1'b0;
        rs_spur = -1; sp3 = -1; sp0a = -1; sp0b = -1;
    endtask

    task automatic ev_check(input ev_kind_t kind, input int idx, input int cycles);
        ev_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_%s at cycle %0d: got an event, required none", kind.name(), cyc);
            return;
        end
        e = sb.pop_front();
        check("event_kind", int'(kind), int'(e.kind));
        check("event_cycle", cyc, e.cyc);
        if (e.kind == EV_START) check("start_onehot", int'(layer_start), 1 << e.idx);
        else if (e.kind == EV_DONE) check("run_cycles_at_done", cycles, e.cycles);
        else begin
            check("err_layer", idx, e.idx);
            check("run_cycles_at_error", cycles, e.cycles);
        end
    endtask

    // Layer model reaction to a start pulse: schedule its finish, predict next event
    task automatic schedule(input int k, input int c);
        if (k == 0) first_start = c;
        if (delay[k] != 0) due[k] = c + delay[k];
        if (delay[k] != 0 && delay[k] <= TO - 1) begin
            if (k == NL - 1) sb.push_back('{EV_DONE, c + delay[k] + 1, k, c + delay[k] + 1 - first_start});
            else             sb.push_back('{EV_START, c + delay[k] + 2, k + 1, 0});
        end else begin
            sb.push_back('{EV_ERR, c + TO, k, c + TO - first_start});
        end
        if (spur_en && k == 1) begin
            rs_spur = c + 3;
            sp3     = c + 5;
            sp0a    = c + 7;
            sp0b    = c + 9;
        end
    endtask

    task automatic observe();
        int k;
        if (layer_start != '0) begin
            k = -1;
            for (int i = NL - 1; i >= 0; i--) if (layer_start[i]) k = i;
            ev_check(EV_START, k, 0);
            if (k >= 0) schedule(k, cyc);
        end
        if (run_done) begin
            n_done++;
            ev_check(EV_DONE, 0, int'(run_cycles));
        end
        if (run_error && !prev_err) ev_check(EV_ERR, int'(err_layer), int'(run_cycles));
        prev_err = run_error;
    endtask

    task automatic drive();
        logic [NL-1:0] lf;
        run_start = (cyc == rs_spur);
        abort     = 1'b0;
        err_clear = 1'b0;
        for (int k = 0; k < NL; k++) lf[k] = (due[k] == cyc);
        if (cyc == sp3) lf[3] = 1'b1;
        if (cyc == sp0a || cyc == sp0b) lf[0] = 1'b1;
        layer_finish = lf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        observe();
        drive();
    endtask

    task automatic begin_run();
        run_start = 1'b1;
        sb.push_back('{EV_START, cyc + 1, 0, 0});
    endtask

    task automatic run_and_wait(input int budget);
        int n;
        bit fin;
        begin_run();
        n   = 0;
        fin = 1'b0;
        while (!fin && n < budget) begin
            step();
            n++;
            if (run_done || run_error) fin = 1'b1;
        end
        if (!fin) begin
            n_vec++;
            n_miss++;
            $display("FAIL run_end at cycle %0d: got no run_done/run_error, required one within %0d cycles", cyc, budget);
        end
    endtask

    task automatic wait_start(input int k, input int budget);
        int n = 0;
        while (!layer_start[k] && n < budget) begin
            step();
            n++;
        end
        if (!layer_start[k]) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_start%0d at cycle %0d: got no start pulse, required one", k, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_layer_start"},  int'(layer_start),  0);
        check({tag, "_active_layer"}, int'(active_layer), 0);
        check({tag, "_busy"},         int'(busy),         0);
        check({tag, "_run_done"},     int'(run_done),     0);
        check({tag, "_run_error"},    int'(run_error),    0);
        check({tag, "_err_layer"},    int'(err_layer),    0);
        check({tag, "_run_cycles"},   int'(run_cycles),   0);
    endtask

    task automatic set_delays(input int d);
        for (int k = 0; k < NL; k++) delay[k] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done0;

        tbl[0] = '{'{20, 20, 20, 20, 20}, 1'b0, 1'b0, 0, 109};
        tbl[1] = '{'{ 1,  1,  1,  1,  1}, 1'b0, 1'b0, 0,  14};
        tbl[2] = '{'{ 5, 10,  3, 49,  7}, 1'b0, 1'b0, 0,  83};
        tbl[3] = '{'{20, 20,  0, 20, 20}, 1'b0, 1'b1, 2,  94};
        tbl[4] = '{'{20, 20, 20, 20, 20}, 1'b1, 1'b0, 0, 109};
        tbl[5] = '{'{ 1,  2,  3,  4, 50}, 1'b0, 1'b1, 4,  68};

        reset_n      = 1'b0;
        run_start    = 1'b0;
        abort        = 1'b0;
        err_clear    = 1'b0;
        layer_finish = '0;
        clear_model();
        set_delays(20);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        reset_n = 1'b1;
        step();
        check_reset_outputs("after_reset");

        // Table of runs
        for (int i = 0; i < $size(tbl); i++) begin
            for (int k = 0; k < NL; k++) delay[k] = tbl[i].d[k];
            spur_en = tbl[i].spur;
            run_and_wait(600);
            check("run_error_flag", int'(run_error), int'(tbl[i].exp_err));
            check("run_cycles", int'(run_cycles), tbl[i].exp_cycles);
            if (tbl[i].exp_err) begin
                check("err_layer_final", int'(err_layer), tbl[i].exp_layer);
                repeat (3) step();
                check("no_start_in_error", int'(run_error), 1);
                err_clear = 1'b1;
                step();
                check("err_clear_drops", int'(run_error), 0);
            end else begin
                step();
                check("run_cycles_hold", int'(run_cycles), tbl[i].exp_cycles);
            end
            check("busy_after_run", int'(busy), 0);
            repeat (3) step();
            check("pending_events", sb.size(), 0);
            clear_model();
        end

        // Abort while waiting on layer 3
        set_delays(20);
        begin_run();
        wait_start(3, 200);
        repeat (5) step();
        abort = 1'b1;
        sb.delete();
        n_done0 = n_done;
        step();
        check("abort_busy", int'(busy), 0);
        check("abort_active_layer", int'(active_layer), 0);
        repeat (30) step();
        check("abort_no_done", n_done, n_done0);
        clear_model();

        // Timeout on layer 0, run_start ignored in ERROR, then abort out of ERROR
        set_delays(20);
        delay[0] = 0;
        run_and_wait(200);
        check("error_before_abort", int'(run_error), 1);
        run_start = 1'b1;
        step();
        check("error_ignores_run_start", int'(run_error), 1);
        check("error_not_busy", int'(busy), 0);
        abort = 1'b1;
        step();
        check("abort_clears_error", int'(run_error), 0);
        check("abort_no_done_pulse", int'(run_done), 0);
        clear_model();
        set_delays(20);
        run_and_wait(300);
        check("run_after_abort_cycles", int'(run_cycles), 109);
        check("run_after_abort_error", int'(run_error), 0);
        step();
        clear_model();

        // Asynchronous reset in the middle of layer 1
        set_delays(20);
        begin_run();
        wait_start(1, 200);
        repeat (4) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        clear_model();
        repeat (3) step();
        check_reset_outputs("reset_held");
        reset_n = 1'b1;
        step();
        run_and_wait(300);
        check("run_after_reset_cycles", int'(run_cycles), 109);
        step();
        check("pending_after_reset_run", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
